// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds the scan FSM state type, the digit-count limits and the anode-pattern helper.
// Used by seg7_scan_ctrl.
package seg7_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int SEL_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  // Anode pattern for one digit slot. When lit, only bit sel is at the active
  // level. Otherwise every bit is at the inactive level.
  function automatic logic [MAX_DIGITS-1:0] anode_level(
    input logic [SEL_W-1:0] sel,
    input logic             lit,
    input logic             active_low
  );
    logic [MAX_DIGITS-1:0] drv;
    drv = '0;
    if (lit) drv[sel] = 1'b1;
    return active_low ? ~drv : drv;
  endfunction

endpackage

// File: rtl/seg7_dwell_cnt.sv
// Loadable down-counter that times both the BLANK and the SHOW intervals.
// Ports: clk, rst (sync, active-high), clr_i (force to 0), load_i/load_val_i
//        (load length-1), done_o (high while the count is 0, i.e. last cycle).
module seg7_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A load of N-1 makes done_o high on the Nth cycle of the interval.
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment display scan controller: IDLE -> (BLANK -> SHOW) per digit.
// Ports: clk, rst (sync, active-high), en, digit_mask[7:0] in; sel, anode,
//        seg_oe, frame_start out (all registered). Optional SEG7_SCAN_DP_EN adds dp_in/dp.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter int NUM_DIGITS       = 8,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [MAX_DIGITS-1:0] digit_mask,
`ifdef SEG7_SCAN_DP_EN
  input  logic [MAX_DIGITS-1:0] dp_in,
  output logic                  dp,
`endif
  output logic [SEL_W-1:0]      sel,
  output logic [MAX_DIGITS-1:0] anode,
  output logic                  seg_oe,
  output logic                  frame_start
);

  // The counter is sized for the SHOW dwell. It is widened only when the
  // blanking interval is longer than the dwell.
  localparam int LEN_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(LEN_MAX + 1);

  localparam logic [CNT_W-1:0]      SHOW_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [SEL_W-1:0]      LAST_SEL   = SEL_W'(NUM_DIGITS - 1);
  localparam logic                  ACT_LOW    = (ANODE_ACTIVE_LOW != 0);
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF  = ACT_LOW ? '1 : '0;

  state_e                state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [MAX_DIGITS-1:0] anode_q;
  logic                  seg_oe_q;
  logic                  frame_start_q;
`ifdef SEG7_SCAN_DP_EN
  logic                  dp_q;
`endif

  logic [SEL_W-1:0] sel_d;
  logic             cnt_clr;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done;

  // Index of the next digit, wrapping at NUM_DIGITS.
  assign sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;

  // Counter control: the counter reloads on every entry to BLANK or SHOW.
  // Dropping en or asserting rst clears it.
  always_comb begin
    cnt_clr  = rst | ~en;
    cnt_load = 1'b0;
    cnt_val  = BLANK_LOAD;
    unique case (state_q)
      IDLE: begin
        cnt_load = 1'b1;
        cnt_val  = BLANK_LOAD;
      end
      BLANK: begin
        cnt_load = cnt_done;
        cnt_val  = SHOW_LOAD;
      end
      SHOW: begin
        cnt_load = cnt_done;
        cnt_val  = BLANK_LOAD;
      end
      default: begin
        cnt_load = 1'b0;
        cnt_val  = BLANK_LOAD;
      end
    endcase
  end

  seg7_dwell_cnt #(
    .W (CNT_W)
  ) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  // The state and all outputs are registered together. While in SHOW, the
  // anode is recomputed every cycle from digit_mask, so a mask change appears
  // on the next cycle.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      anode_q       <= ANODE_OFF;
      seg_oe_q      <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_q          <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q       <= BLANK;
          sel_q         <= '0;
          anode_q       <= ANODE_OFF;
          seg_oe_q      <= 1'b0;
          frame_start_q <= 1'b1;
`ifdef SEG7_SCAN_DP_EN
          dp_q          <= 1'b0;
`endif
        end
        BLANK: begin
          frame_start_q <= 1'b0;
          if (cnt_done) begin
            state_q  <= SHOW;
            seg_oe_q <= 1'b1;
            anode_q  <= anode_level(sel_q, digit_mask[sel_q], ACT_LOW);
`ifdef SEG7_SCAN_DP_EN
            dp_q     <= digit_mask[sel_q] & dp_in[sel_q];
`endif
          end else begin
            anode_q  <= ANODE_OFF;
            seg_oe_q <= 1'b0;
          end
        end
        SHOW: begin
          if (cnt_done) begin
            state_q       <= BLANK;
            sel_q         <= sel_d;
            frame_start_q <= (sel_d == '0);
            anode_q       <= ANODE_OFF;
            seg_oe_q      <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_q          <= 1'b0;
`endif
          end else begin
            frame_start_q <= 1'b0;
            seg_oe_q      <= 1'b1;
            anode_q       <= anode_level(sel_q, digit_mask[sel_q], ACT_LOW);
`ifdef SEG7_SCAN_DP_EN
            dp_q          <= digit_mask[sel_q] & dp_in[sel_q];
`endif
          end
        end
        default: begin
          state_q       <= IDLE;
          sel_q         <= '0;
          anode_q       <= ANODE_OFF;
          seg_oe_q      <= 1'b0;
          frame_start_q <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
          dp_q          <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign sel         = sel_q;
  assign anode       = anode_q;
  assign seg_oe      = seg_oe_q;
  assign frame_start = frame_start_q;
`ifdef SEG7_SCAN_DP_EN
  assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: an 8-digit instance and a 3-digit instance
// share their stimulus. A timeline model derives the expected outputs from the number
// of cycles elapsed since the scan started.
module tb_seg7_scan_ctrl;

  localparam int DIV = 4;
  localparam int BLK = 2;
  localparam int P   = DIV + BLK;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] digit_mask;
  logic [2:0] sel8, sel3;
  logic [7:0] an8, an3;
  logic       oe8, oe3, fs8, fs3;
`ifdef SEG7_SCAN_DP_EN
  logic [7:0] dp_in = 8'h00;
  logic       dp8, dp3;
`endif

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYCLES(BLK), .NUM_DIGITS(8), .ANODE_ACTIVE_LOW(1)) dut8 (
    .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
`ifdef SEG7_SCAN_DP_EN
    .dp_in(dp_in), .dp(dp8),
`endif
    .sel(sel8), .anode(an8), .seg_oe(oe8), .frame_start(fs8));

  seg7_scan_ctrl #(.CLK_DIV(DIV), .BLANK_CYCLES(BLK), .NUM_DIGITS(3), .ANODE_ACTIVE_LOW(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .digit_mask(digit_mask),
`ifdef SEG7_SCAN_DP_EN
    .dp_in(dp_in), .dp(dp3),
`endif
    .sel(sel3), .anode(an3), .seg_oe(oe3), .frame_start(fs3));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model. t_m is the number of cycles since the first BLANK cycle of the scan.
  bit         act_m [2];
  int         t_m   [2];
  int         nd    [2] = '{8, 3};
  logic [7:0] ms;

  task automatic cmp(input int i, input logic [2:0] s, input logic [7:0] a,
                     input logic o, input logic f);
    int         dig;
    bit         show;
    bit         fexp;
    logic [7:0] ea;
    dig  = act_m[i] ? (t_m[i] / P) % nd[i] : 0;
    show = act_m[i] && ((t_m[i] % P) >= BLK);
    fexp = act_m[i] && ((t_m[i] % (nd[i] * P)) == 0);
    ea   = 8'hFF;
    if (show && ms[dig]) ea[dig] = 1'b0;
    check($sformatf("model sel n%0d", nd[i]),    32'(s), 32'(dig));
    check($sformatf("model anode n%0d", nd[i]),  32'(a), 32'(ea));
    check($sformatf("model seg_oe n%0d", nd[i]), 32'(o), 32'(show));
    check($sformatf("model frame n%0d", nd[i]),  32'(f), 32'(fexp));
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || !en)     act_m[i] = 1'b0;
      else if (!act_m[i]) begin act_m[i] = 1'b1; t_m[i] = 0; end
      else                t_m[i] = t_m[i] + 1;
    end
    ms = digit_mask;
    #1;
    cmp(0, sel8, an8, oe8, fs8);
    cmp(1, sel3, an3, oe3, fs3);
  end

  function automatic logic fsx(input int i);
    return (i == 0) ? fs8 : fs3;
  endfunction

  // Measures the number of cycles between two frame_start pulses. Returns -1 on timeout.
  task automatic frame_period(input int i, output int per);
    int c;
    per = -1;
    c = 0;
    while (!fsx(i) && c < 200) begin @(negedge clk); c++; end
    if (fsx(i)) begin
      c = 0;
      do begin @(negedge clk); c++; end while (!fsx(i) && c < 200);
      if (fsx(i)) per = c;
    end
  endtask

  // Waits until the 8-digit instance shows digit s. ok=0 on timeout.
  task automatic wait_show(input logic [2:0] s, output bit ok);
    int c;
    c = 0;
    while (!(sel8 == s && oe8) && c < 200) begin @(negedge clk); c++; end
    ok = (sel8 == s && oe8);
  endtask

  initial begin
    int per;
    int len;
    bit ok;
    rst = 1'b1; en = 1'b0; digit_mask = 8'hFF;
    repeat (2) @(negedge clk);
    check("reset anode", 32'(an8), 32'hFF);
    check("reset sel", 32'(sel8), 32'h0);
    check("reset seg_oe", 32'(oe8), 32'h0);
    check("reset frame_start", 32'(fs8), 32'h0);
    check("reset anode n3", 32'(an3), 32'hFF);

    rst = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("start frame_start", 32'(fs8), 32'h1);
    check("start blank anode", 32'(an8), 32'hFF);
    check("start sel", 32'(sel8), 32'h0);
    @(negedge clk);
    check("blank2 frame_start", 32'(fs8), 32'h0);
    check("blank2 seg_oe", 32'(oe8), 32'h0);
    for (int k = 0; k < DIV; k++) begin
      @(negedge clk);
      check("digit0 anode", 32'(an8), 32'hFE);
      check("digit0 seg_oe", 32'(oe8), 32'h1);
      check("digit0 sel", 32'(sel8), 32'h0);
    end
    @(negedge clk);
    check("digit1 sel", 32'(sel8), 32'h1);
    check("digit1 blank anode", 32'(an8), 32'hFF);

    frame_period(0, per);
    check("frame period n8", 32'(per), 32'd48);
    frame_period(1, per);
    check("frame period n3", 32'(per), 32'd18);

    // A masked digit stays dark but keeps its full dwell.
    digit_mask = 8'hFB;
    wait_show(3'd2, ok);
    check("masked digit reached", 32'(ok), 32'h1);
    check("masked anode", 32'(an8), 32'hFF);
    check("masked seg_oe", 32'(oe8), 32'h1);
    len = 0;
    while (oe8 && sel8 == 3'd2 && len < 20) begin @(negedge clk); len++; end
    check("masked dwell", 32'(len), 32'(DIV));
    digit_mask = 8'hFF;

    // Dropping en during a SHOW interval returns to IDLE, and raising it again restarts the scan.
    wait_show(3'd5, ok);
    check("sel5 reached", 32'(ok), 32'h1);
    en = 1'b0;
    @(negedge clk);
    check("disable anode", 32'(an8), 32'hFF);
    check("disable sel", 32'(sel8), 32'h0);
    check("disable seg_oe", 32'(oe8), 32'h0);
    en = 1'b1;
    @(negedge clk);
    check("restart frame_start", 32'(fs8), 32'h1);
    check("restart sel", 32'(sel8), 32'h0);

    // Reset in the middle of a SHOW interval blanks the display immediately.
    wait_show(3'd3, ok);
    check("sel3 reached", 32'(ok), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid-show reset anode", 32'(an8), 32'hFF);
    check("mid-show reset seg_oe", 32'(oe8), 32'h0);
    check("mid-show reset sel", 32'(sel8), 32'h0);
    rst = 1'b0;

    // Randomized run: occasional en drops, resets and mask changes, all checked by the model.
    repeat (3000) begin
      @(negedge clk);
      en  = ($urandom_range(0, 127) != 0);
      rst = ($urandom_range(0, 255) == 0);
      if ($urandom_range(0, 15) == 0) digit_mask = 8'($urandom);
    end
    rst = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
